// File: rtl/number_entry.sv
// Keypad number entry: collects up to four BCD digits, supports backspace/clear/enter,
// and commits the value to a Nios PIO input. Optional key lockout under NUMBER_ENTRY_LOCKOUT_EN.
module number_entry #(
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] entry_bcd,
    output logic [2:0]  digit_count,
    output logic [15:0] numbers,
    output logic        number_strobe,
    output logic        full
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        accept_s;
    logic        is_digit_s;
    logic [15:0] entry_next_s;
    logic [2:0]  count_next_s;
    logic        commit_s;
    logic        commit_r;

    assign is_digit_s = (key_code <= 4'h9);

`ifdef NUMBER_ENTRY_LOCKOUT_EN
    logic [7:0] lock_cnt_r;

    assign accept_s = key_valid && (key_code <= 4'hC) && (lock_cnt_r == 8'd0);

    // Lockout counter: reloaded on every accepted key, counts down to zero otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_cnt_r <= 8'd0;
        end else if (accept_s) begin
            lock_cnt_r <= 8'(LOCKOUT_CYCLES);
        end else if (lock_cnt_r != 8'd0) begin
            lock_cnt_r <= lock_cnt_r - 8'd1;
        end else begin
            lock_cnt_r <= lock_cnt_r;
        end
    end
`else
    assign accept_s = key_valid && (key_code <= 4'hC);
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        if (!accept_s) begin
            state_next_s = state_r;
        end else if (is_digit_s) begin
            if ((state_r == DONE) || (digit_count < 3'd4)) begin
                state_next_s = ENTRY;
            end else begin
                state_next_s = state_r;
            end
        end else begin
            case (key_code)
                4'hA: begin
                    if ((state_r != DONE) && (digit_count != 3'd0)) begin
                        state_next_s = (digit_count == 3'd1) ? IDLE : ENTRY;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                4'hB:    state_next_s = IDLE;
                4'hC:    state_next_s = DONE;
                default: state_next_s = state_r;
            endcase
        end
    end

    // Datapath next values; a full entry silently drops further digits
    always_comb begin
        entry_next_s = entry_bcd;
        count_next_s = digit_count;
        commit_s     = 1'b0;
        if (!accept_s) begin
            commit_s = 1'b0;
        end else if (is_digit_s) begin
            if (state_r == DONE) begin
                entry_next_s = {12'h000, key_code};
                count_next_s = 3'd1;
            end else if (digit_count < 3'd4) begin
                entry_next_s = {entry_bcd[11:0], key_code};
                count_next_s = digit_count + 3'd1;
            end else begin
                entry_next_s = entry_bcd;
            end
        end else begin
            case (key_code)
                4'hA: begin
                    if ((state_r != DONE) && (digit_count != 3'd0)) begin
                        entry_next_s = {4'h0, entry_bcd[15:4]};
                        count_next_s = digit_count - 3'd1;
                    end else begin
                        entry_next_s = entry_bcd;
                    end
                end
                4'hB: begin
                    entry_next_s = 16'h0000;
                    count_next_s = 3'd0;
                end
                4'hC:    commit_s = 1'b1;
                default: commit_s = 1'b0;
            endcase
        end
    end

    // Registered outputs; strobe trails the numbers update by one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_bcd     <= 16'h0000;
            digit_count   <= 3'd0;
            full          <= 1'b0;
            numbers       <= 16'h0000;
            commit_r      <= 1'b0;
            number_strobe <= 1'b0;
        end else begin
            entry_bcd     <= entry_next_s;
            digit_count   <= count_next_s;
            full          <= (count_next_s == 3'd4);
            commit_r      <= commit_s;
            number_strobe <= commit_r;
            if (commit_s) begin
                numbers <= entry_bcd;
            end else begin
                numbers <= numbers;
            end
        end
    end

endmodule

// File: tb/tb_number_entry.sv
// Self-checking bench for number_entry: table of key presses with a scoreboard queue,
// plus hand-written reset and lockout sequences.
module tb_number_entry;

    typedef struct {
        logic        kv;
        logic [3:0]  code;
        logic [15:0] e_bcd;
        logic [2:0]  e_cnt;
        logic [15:0] e_num;
        logic        e_strb;
    } vec_t;

    localparam int GAP = 18;
    localparam int NVEC = 31;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] entry_bcd;
    logic [2:0]  digit_count;
    logic [15:0] numbers;
    logic        number_strobe;
    logic        full;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t exp_q[$];
    vec_t tbl[NVEC];

    always #5 clk = ~clk;

    number_entry dut (
        .clk(clk),
        .reset(reset),
        .key_valid(key_valid),
        .key_code(key_code),
        .entry_bcd(entry_bcd),
        .digit_count(digit_count),
        .numbers(numbers),
        .number_strobe(number_strobe),
        .full(full)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [15:0] eb, input logic [2:0] ec,
                             input logic [15:0] en);
        chk({tag, " entry_bcd"}, entry_bcd, eb);
        chk({tag, " digit_count"}, {13'd0, digit_count}, {13'd0, ec});
        chk({tag, " full"}, {15'd0, full}, {15'd0, (ec == 3'd4)});
        chk({tag, " numbers"}, numbers, en);
    endtask

    task automatic press(input vec_t v, input int idx);
        vec_t e;
        string tag;
        tag = $sformatf("vec%0d", idx);
        exp_q.push_back(v);
        @(negedge clk);
        key_valid = v.kv;
        key_code  = v.code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
        e = exp_q.pop_front();
        chk_state(tag, e.e_bcd, e.e_cnt, e.e_num);
        chk({tag, " strobe_early"}, {15'd0, number_strobe}, 16'd0);
        @(negedge clk);
        chk({tag, " strobe"}, {15'd0, number_strobe}, {15'd0, e.e_strb});
        @(negedge clk);
        chk({tag, " strobe_width"}, {15'd0, number_strobe}, 16'd0);
        repeat (GAP) @(negedge clk);
        n_vec++;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'h1, 16'h0001, 3'd1, 16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 4'h2, 16'h0012, 3'd2, 16'h0000, 1'b0};
        tbl[2]  = '{1'b1, 4'h3, 16'h0123, 3'd3, 16'h0000, 1'b0};
        tbl[3]  = '{1'b1, 4'h4, 16'h1234, 3'd4, 16'h0000, 1'b0};
        tbl[4]  = '{1'b1, 4'hC, 16'h1234, 3'd4, 16'h1234, 1'b1};
        tbl[5]  = '{1'b1, 4'hB, 16'h0000, 3'd0, 16'h1234, 1'b0};
        tbl[6]  = '{1'b1, 4'h9, 16'h0009, 3'd1, 16'h1234, 1'b0};
        tbl[7]  = '{1'b1, 4'h8, 16'h0098, 3'd2, 16'h1234, 1'b0};
        tbl[8]  = '{1'b1, 4'h7, 16'h0987, 3'd3, 16'h1234, 1'b0};
        tbl[9]  = '{1'b1, 4'h6, 16'h9876, 3'd4, 16'h1234, 1'b0};
        tbl[10] = '{1'b1, 4'h5, 16'h9876, 3'd4, 16'h1234, 1'b0};
        tbl[11] = '{1'b1, 4'hA, 16'h0987, 3'd3, 16'h1234, 1'b0};
        tbl[12] = '{1'b1, 4'hB, 16'h0000, 3'd0, 16'h1234, 1'b0};
        tbl[13] = '{1'b1, 4'h4, 16'h0004, 3'd1, 16'h1234, 1'b0};
        tbl[14] = '{1'b1, 4'h2, 16'h0042, 3'd2, 16'h1234, 1'b0};
        tbl[15] = '{1'b0, 4'h9, 16'h0042, 3'd2, 16'h1234, 1'b0};
        tbl[16] = '{1'b1, 4'hB, 16'h0000, 3'd0, 16'h1234, 1'b0};
        tbl[17] = '{1'b1, 4'hC, 16'h0000, 3'd0, 16'h0000, 1'b1};
        tbl[18] = '{1'b1, 4'hC, 16'h0000, 3'd0, 16'h0000, 1'b1};
        tbl[19] = '{1'b1, 4'hE, 16'h0000, 3'd0, 16'h0000, 1'b0};
        tbl[20] = '{1'b1, 4'hA, 16'h0000, 3'd0, 16'h0000, 1'b0};
        tbl[21] = '{1'b1, 4'h3, 16'h0003, 3'd1, 16'h0000, 1'b0};
        tbl[22] = '{1'b1, 4'hB, 16'h0000, 3'd0, 16'h0000, 1'b0};
        tbl[23] = '{1'b1, 4'hA, 16'h0000, 3'd0, 16'h0000, 1'b0};
        tbl[24] = '{1'b1, 4'h1, 16'h0001, 3'd1, 16'h0000, 1'b0};
        tbl[25] = '{1'b1, 4'hC, 16'h0001, 3'd1, 16'h0001, 1'b1};
        tbl[26] = '{1'b1, 4'hA, 16'h0001, 3'd1, 16'h0001, 1'b0};
        tbl[27] = '{1'b1, 4'h5, 16'h0005, 3'd1, 16'h0001, 1'b0};
        tbl[28] = '{1'b1, 4'hF, 16'h0005, 3'd1, 16'h0001, 1'b0};
        tbl[29] = '{1'b1, 4'hA, 16'h0000, 3'd0, 16'h0001, 1'b0};
        tbl[30] = '{1'b1, 4'hA, 16'h0000, 3'd0, 16'h0001, 1'b0};

        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        #2;
        chk_state("reset", 16'h0000, 3'd0, 16'h0000);
        chk("reset strobe", {15'd0, number_strobe}, 16'd0);
        n_vec++;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            press(tbl[i], i);
        end

        // Reset in the middle of an entry, right after an accepted key
        press('{1'b1, 4'h1, 16'h0001, 3'd1, 16'h0001, 1'b0}, 100);
        press('{1'b1, 4'h2, 16'h0012, 3'd2, 16'h0001, 1'b0}, 101);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'h3;
        @(posedge clk);
        #2;
        key_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk_state("async_reset", 16'h0000, 3'd0, 16'h0000);
        chk("async_reset strobe", {15'd0, number_strobe}, 16'd0);
        @(negedge clk);
        reset     = 1'b0;
        key_valid = 1'b1;
        key_code  = 4'h7;
        @(negedge clk);
        key_valid = 1'b0;
        chk_state("after_reset", 16'h0007, 3'd1, 16'h0000);
        n_vec++;
        repeat (GAP) @(negedge clk);

        press('{1'b1, 4'hB, 16'h0000, 3'd0, 16'h0000, 1'b0}, 102);

`ifdef NUMBER_ENTRY_LOCKOUT_EN
        // 5 accepted, 6 at +2 and +16 locked out, 6 at +17 accepted
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 17) chk_state("lockout_hold", 16'h0005, 3'd1, 16'h0000);
            key_valid = (c == 0) || (c == 2) || (c == 16) || (c == 17);
            key_code  = (c == 0) ? 4'h5 : 4'h6;
        end
        @(negedge clk);
        key_valid = 1'b0;
        chk_state("lockout_release", 16'h0056, 3'd2, 16'h0000);
`else
        // Back-to-back keys are both accepted
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'h5;
        @(negedge clk);
        key_code  = 4'h6;
        @(negedge clk);
        key_valid = 1'b0;
        chk_state("back_to_back", 16'h0056, 3'd2, 16'h0000);
`endif
        n_vec++;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/number_entry.md
NUMBER_ENTRY -- requirements
Module: number_entry

Interface
REQ-001 SHALL have parameter LOCKOUT_CYCLES, default 16: cycles after an accepted key during which further key_valid is ignored; legal range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port key_valid  input  1  one-cycle strobe qualifying key_code.
REQ-005 SHALL have port key_code  input  4  0x0-0x9 digit, 0xA backspace, 0xB clear, 0xC enter, 0xD-0xF reserved.
REQ-006 SHALL have port entry_bcd  output  16  live 4-digit packed-BCD value being typed, last digit in [3:0].
REQ-007 SHALL have port digit_count  output  3  digits currently held, 0..4.
REQ-008 SHALL have port numbers  output  16  last committed BCD value; drives the 16-bit Nios PIO input port.
REQ-009 SHALL have port number_strobe  output  1  one-cycle pulse in the cycle after numbers is updated.
REQ-010 SHALL have port full  output  1  high while digit_count == 4.

Function
REQ-011 SHALL implement states IDLE (count 0), ENTRY (count 1..4), DONE (value committed); encoding is free.
REQ-012 SHALL accept a key only when key_valid is high, the code is not reserved, and no lockout is active; otherwise state and outputs hold.
REQ-013 Digit in IDLE or ENTRY with count < 4 SHALL do entry_bcd <= {entry_bcd[11:0], digit}, count +1, state ENTRY.
REQ-014 Digit with count == 4 SHALL be accepted but ignored (no shift, no count change, lockout still starts).
REQ-015 Digit in DONE SHALL start a new entry: entry_bcd <= {12'h000, digit}, count 1, state ENTRY.
REQ-016 Backspace SHALL do entry_bcd <= {4'h0, entry_bcd[15:4]}, count -1; at count 0, or in DONE, it SHALL be a no-op; reaching count 0 SHALL go to IDLE.
REQ-017 Clear SHALL zero entry_bcd and count and go to IDLE from any state; numbers is unchanged.
REQ-018 Enter SHALL copy entry_bcd to numbers, go to DONE, and pulse number_strobe one cycle later; enter with count 0 SHALL commit 0x0000; enter in DONE SHALL recommit the same value and pulse again.
REQ-019 entry_bcd and digit_count SHALL update one cycle after the accepting key_valid; numbers SHALL update one cycle after, and number_strobe two cycles after, the accepting key_valid.
REQ-020 In DONE, entry_bcd SHALL keep the committed value and digit_count its final count until the next accepted key.
REQ-021 numbers SHALL change only on an accepted enter or on reset.

Reset
REQ-022 Reset asserted SHALL immediately force state IDLE, entry_bcd 0x0000, digit_count 0, numbers 0x0000, number_strobe 0, full 0, lockout counter 0.
REQ-023 Reset mid-entry or mid-lockout SHALL discard all progress; the first key_valid after reset deasserts SHALL be accepted.

Configuration
REQ-024 With macro NUMBER_ENTRY_LOCKOUT_EN defined, each accepted key SHALL load a counter with LOCKOUT_CYCLES; key_valid is ignored while the counter is nonzero, and the counter decrements each cycle.
REQ-025 Without NUMBER_ENTRY_LOCKOUT_EN, no counter SHALL exist; every valid, non-reserved key_valid is accepted, including on consecutive cycles.

Verification
REQ-026 Keys 1,2,3,4,enter (spaced beyond lockout) -> entry_bcd 0x1234, full 1, numbers 0x1234, one number_strobe pulse.
REQ-027 Keys 9,8,7,6,5 -> entry_bcd 0x9876, count 4; then backspace -> 0x0987, count 3, full 0.
REQ-028 Keys 4,2,clear,enter -> entry_bcd 0x0000, numbers 0x0000, strobe pulses; clear alone leaves a prior numbers 0x1234 intact.
REQ-029 With lockout enabled and LOCKOUT_CYCLES=16, keys 5 and 6 two cycles apart -> only 5 accepted (entry_bcd 0x0005); key 6 at cycle 17 -> 0x0056. With lockout disabled -> 0x0056 after both.
REQ-030 Reset asserted mid-entry at 0x0012 -> all outputs 0 asynchronously; key 7 immediately after release -> entry_bcd 0x0007.
REQ-031 Code 0xE, and backspace at count 0 -> no output change; enter then key 3 -> numbers held, entry_bcd 0x0003.
